breath_sequencer: RTL and testbench
===================================

BREATH_SEQUENCER -- requirements
Module: breath_sequencer

Interface
REQ-001 Parameter BITS, default 4: brightness level width.
REQ-002 Parameter DIV_BITS, default 16: prescaler divide-value width.
REQ-003 Parameter HOLD_BITS, default 8: hold-count width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-clk request to begin breathing; honoured only in IDLE.
REQ-007 stop  input  1  one-clk request to end breathing gracefully.
REQ-008 div  input  DIV_BITS  prescaler value; one step tick every div+1 clocks.
REQ-009 hold  input  HOLD_BITS  ticks to dwell at full and zero brightness.
REQ-010 level  output  BITS  current brightness level.
REQ-011 dir  output  1  1 while falling or holding high, else 0.
REQ-012 busy  output  1  1 in any state except IDLE.
REQ-013 cycle_done  output  1  one-clk pulse on each entry to HOLD_LOW.
REQ-014 led  output  1  PWM output driven from level.

Function
REQ-015 States SHALL be IDLE, RISE, HOLD_HIGH, FALL, HOLD_LOW.
REQ-016 In IDLE with start=1 and stop=0: latch div and hold, clear prescaler and hold counter, level=0, enter RISE next clock.
REQ-017 start SHALL be ignored outside IDLE; start and stop in the same IDLE cycle SHALL leave the block in IDLE.
REQ-018 Tick SHALL assert for one clock when the prescaler equals the latched div; the prescaler then wraps to 0.
REQ-019 Mid-run changes to div/hold SHALL have no effect until the next start.
REQ-020 RISE: level+1 per tick; on the tick that makes level all-ones, enter HOLD_HIGH.
REQ-021 HOLD_HIGH/HOLD_LOW: count ticks; after hold ticks, leave; hold=0 leaves on the next tick (1-tick dwell minimum).
REQ-022 HOLD_HIGH exit to FALL; FALL: level-1 per tick; on the tick that makes level 0, enter HOLD_LOW and pulse cycle_done.
REQ-023 HOLD_LOW exit: to IDLE if stop_pending, else RISE.
REQ-024 stop while busy SHALL set stop_pending; the sequence continues until HOLD_LOW completes; stop_pending clears on IDLE entry.
REQ-025 stop in IDLE SHALL be ignored.
REQ-026 level SHALL never wrap; arithmetic is saturating by construction of the state transitions.
REQ-027 PWM: free-running BITS-bit counter pwm_cnt; led = busy and (pwm_cnt < duty); level 0 gives led=0; full level gives (2^BITS-1)/2^BITS duty.
REQ-028 Full period SHALL be (2*(2^BITS-1) + 2*max(hold,1)) ticks, one tick = div+1 clocks.

Reset
REQ-029 rst_n low SHALL force, asynchronously: state=IDLE, level=0, dir=0, busy=0, cycle_done=0, led=0, prescaler=0, pwm_cnt=0, stop_pending=0.
REQ-030 Reset mid-run SHALL abort immediately; after release the block waits in IDLE for start.

Configuration
REQ-031 Macro BREATH_SEQUENCER_GAMMA_EN defined: duty = upper BITS bits of level*level (2*BITS-bit product).
REQ-032 Macro absent: duty = level (linear); no multiplier instantiated.

Structure
REQ-033 Shared package breath_pkg SHALL hold the state enum and state encodings.
REQ-034 PWM counter and compare SHALL be the sub-module breath_pwm (inputs clk, rst_n, duty, enable; output led).

Verification
REQ-035 BITS=4, div=0, hold=2, start pulse -> level 0..15 over 15 clks, 2 clks at 15, 15..0, cycle_done at level 0, period 34 clks.
REQ-036 div=3 -> level changes exactly every 4 clks; change div mid-run to 0 -> step rate unchanged.
REQ-037 stop during RISE at level 5 -> continues to 15, falls to 0, holds, IDLE; busy drops; no second RISE.
REQ-038 start+stop same cycle in IDLE -> stays IDLE, busy=0; start while in FALL -> no effect.
REQ-039 rst_n low in HOLD_HIGH -> level=0, led=0, busy=0 without clock edge; restart behaves as REQ-035.
REQ-040 Level 8 held (hold large): linear -> led high 8 of 16 clks; GAMMA_EN -> duty=4, led high 4 of 16.

Source files
------------

// File: rtl/breath_pkg.sv
// Shared types for the breathing-LED sequencer: state enum and its encodings.
package breath_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRise     = 3'd1,
        StHoldHigh = 3'd2,
        StFall     = 3'd3,
        StHoldLow  = 3'd4
    } breath_state_e;

endpackage

// File: rtl/breath_pwm.sv
// Free-running PWM counter and compare; led is high while cnt < duty and enabled.
module breath_pwm #(
    parameter int unsigned BITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] duty,
    input  logic            enable,
    output logic            led
);

    localparam logic [BITS-1:0] CntOne = {{(BITS-1){1'b0}}, 1'b1};

    logic [BITS-1:0] cnt_q;

    // Counter wraps naturally every 2^BITS clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntOne;
        end
    end

    assign led = enable && (cnt_q < duty);

endmodule

// File: rtl/breath_sequencer.sv
// Breathing-LED sequencer: ramps level up, holds, ramps down, holds, repeats.
// Optional macro BREATH_SEQUENCER_GAMMA_EN squares the level before PWM compare.
module breath_sequencer
    import breath_pkg::*;
#(
    parameter int unsigned BITS      = 4,
    parameter int unsigned DIV_BITS  = 16,
    parameter int unsigned HOLD_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DIV_BITS-1:0]  div,
    input  logic [HOLD_BITS-1:0] hold,
    output logic [BITS-1:0]      level,
    output logic                 dir,
    output logic                 busy,
    output logic                 cycle_done,
    output logic                 led
);

    localparam logic [BITS-1:0]      LevelOne = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0]      LevelTop = {BITS{1'b1}} - LevelOne;
    localparam logic [DIV_BITS-1:0]  DivOne   = {{(DIV_BITS-1){1'b0}}, 1'b1};
    localparam logic [HOLD_BITS-1:0] HoldOne  = {{(HOLD_BITS-1){1'b0}}, 1'b1};

    breath_state_e        state_q, state_d;
    logic [BITS-1:0]      level_q, level_d;
    logic [DIV_BITS-1:0]  presc_q, presc_d;
    logic [DIV_BITS-1:0]  div_q, div_d;
    logic [HOLD_BITS-1:0] hold_q, hold_d;
    logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;
    logic                 stop_pending_q, stop_pending_d;
    logic                 cycle_done_q, cycle_done_d;
    logic                 tick;
    logic                 hold_last;
    logic [BITS-1:0]      duty;

    assign busy      = (state_q != StIdle);
    assign tick      = busy && (presc_q == div_q);
    // hold=0 still dwells one tick, so it behaves like hold=1.
    assign hold_last = (hold_q == '0) || (hold_cnt_q == hold_q - HoldOne);

    // Next-state, prescaler, level and hold-count logic.
    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        presc_d        = presc_q;
        div_d          = div_q;
        hold_d         = hold_q;
        hold_cnt_d     = hold_cnt_q;
        stop_pending_d = stop_pending_q;
        cycle_done_d   = 1'b0;

        if (busy) begin
            presc_d = tick ? '0 : presc_q + DivOne;
            if (stop) begin
                stop_pending_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                presc_d        = '0;
                stop_pending_d = 1'b0;
                if (start && !stop) begin
                    div_d      = div;
                    hold_d     = hold;
                    hold_cnt_d = '0;
                    level_d    = '0;
                    state_d    = StRise;
                end
            end
            StRise: begin
                if (tick) begin
                    level_d = level_q + LevelOne;
                    if (level_q == LevelTop) begin
                        state_d    = StHoldHigh;
                        hold_cnt_d = '0;
                    end
                end
            end
            StHoldHigh: begin
                if (tick) begin
                    if (hold_last) begin
                        state_d    = StFall;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HoldOne;
                    end
                end
            end
            StFall: begin
                if (tick) begin
                    level_d = level_q - LevelOne;
                    if (level_q == LevelOne) begin
                        state_d      = StHoldLow;
                        hold_cnt_d   = '0;
                        cycle_done_d = 1'b1;
                    end
                end
            end
            StHoldLow: begin
                if (tick) begin
                    if (hold_last) begin
                        hold_cnt_d = '0;
                        // A stop arriving on the final tick is still honoured.
                        if (stop_pending_q || stop) begin
                            state_d        = StIdle;
                            stop_pending_d = 1'b0;
                        end else begin
                            state_d = StRise;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HoldOne;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            level_q        <= '0;
            presc_q        <= '0;
            div_q          <= '0;
            hold_q         <= '0;
            hold_cnt_q     <= '0;
            stop_pending_q <= 1'b0;
            cycle_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            presc_q        <= presc_d;
            div_q          <= div_d;
            hold_q         <= hold_d;
            hold_cnt_q     <= hold_cnt_d;
            stop_pending_q <= stop_pending_d;
            cycle_done_q   <= cycle_done_d;
        end
    end

    assign level      = level_q;
    assign dir        = (state_q == StHoldHigh) || (state_q == StFall);
    assign cycle_done = cycle_done_q;

`ifdef BREATH_SEQUENCER_GAMMA_EN
    logic [2*BITS-1:0] level_sq;
    assign level_sq = {{BITS{1'b0}}, level_q} * {{BITS{1'b0}}, level_q};
    assign duty     = level_sq[2*BITS-1:BITS];
`else
    assign duty = level_q;
`endif

    breath_pwm #(
        .BITS (BITS)
    ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty   (duty),
        .enable (busy),
        .led    (led)
    );

endmodule

// File: tb/tb_breath_sequencer.sv
// Directed self-checking bench for breath_sequencer (BITS=4, DIV_BITS=16, HOLD_BITS=8).
module tb_breath_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] div;
    logic [7:0]  hold;
    logic [3:0]  level;
    logic        dir;
    logic        busy;
    logic        cycle_done;
    logic        led;

    int n_tests;
    int n_fail;

    breath_sequencer #(
        .BITS      (4),
        .DIV_BITS  (16),
        .HOLD_BITS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .div        (div),
        .hold       (hold),
        .level      (level),
        .dir        (dir),
        .busy       (busy),
        .cycle_done (cycle_done),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Expected level after edge e of a div=0, hold=2 run (edge 0 = start edge).
    function automatic int exp_basic_level(input int e);
        int p;
        p = e % 34;
        if (p <= 15) return p;
        if (p <= 17) return 15;
        if (p <= 32) return 32 - p;
        return 0;
    endfunction

    task automatic run_basic(input int n_edges);
        int p;
        div   = 16'd0;
        hold  = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (level !== 4'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start: level=%0d busy=%0b, want level=0 busy=1", level, busy);
        end
        for (int e = 1; e <= n_edges; e++) begin
            step();
            p = e % 34;
            n_tests++;
            if (level !== 4'(exp_basic_level(e))) begin
                n_fail++;
                $display("FAIL basic_level e=%0d: got %0d want %0d", e, level,
                         exp_basic_level(e));
            end
            n_tests++;
            if (dir !== ((p >= 15 && p <= 31) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL basic_dir e=%0d: got %0b", e, dir);
            end
            n_tests++;
            if (cycle_done !== ((p == 32) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL basic_cycle_done e=%0d: got %0b", e, cycle_done);
            end
        end
    endtask

    task automatic test_reset();
        start = 1'b0;
        stop  = 1'b0;
        div   = 16'd0;
        hold  = 8'd0;
        rst_n = 1'b0;
        #3;
        n_tests++;
        if (level !== 4'd0 || dir !== 1'b0 || busy !== 1'b0 || cycle_done !== 1'b0
            || led !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: level=%0d dir=%0b busy=%0b cd=%0b led=%0b, want all 0",
                     level, dir, busy, cycle_done, led);
        end
        do_reset();
        repeat (5) step();
        n_tests++;
        if (busy !== 1'b0 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_idle_wait: busy=%0b level=%0d, want 0 0", busy, level);
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_basic(70);
    endtask

    task automatic test_div();
        do_reset();
        div   = 16'd3;
        hold  = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            step();
            n_tests++;
            if (level !== 4'(e / 4)) begin
                n_fail++;
                $display("FAIL div_level e=%0d: got %0d want %0d", e, level, e / 4);
            end
            if (e == 2) div = 16'd0;
        end
    endtask

    task automatic test_stop();
        int exp_l;
        logic exp_b;
        do_reset();
        div   = 16'd0;
        hold  = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (e <= 15) exp_l = e;
            else if (e == 16) exp_l = 15;
            else if (e <= 31) exp_l = 31 - e;
            else exp_l = 0;
            exp_b = (e <= 31) ? 1'b1 : 1'b0;
            n_tests++;
            if (level !== 4'(exp_l) || busy !== exp_b) begin
                n_fail++;
                $display("FAIL stop_seq e=%0d: level=%0d busy=%0b want %0d %0b", e, level,
                         busy, exp_l, exp_b);
            end
            if (e == 31) begin
                n_tests++;
                if (cycle_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stop_cycle_done: got %0b want 1", cycle_done);
                end
            end
            if (e == 5) stop = 1'b1;
            if (e == 6) stop = 1'b0;
        end
    endtask

    task automatic test_start_stop_idle();
        do_reset();
        div   = 16'd0;
        hold  = 8'd0;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_same: busy=%0b want 0", busy);
        end
        repeat (3) step();
        n_tests++;
        if (busy !== 1'b0 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL start_stop_stay: busy=%0b level=%0d want 0 0", busy, level);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        n_tests++;
        if (level !== 4'd11 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_level: level=%0d dir=%0b want 11 1", level, dir);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (level !== 4'd10 || dir !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_fall: level=%0d dir=%0b busy=%0b want 10 1 1", level, dir,
                     busy);
        end
        step();
        n_tests++;
        if (level !== 4'd9) begin
            n_fail++;
            $display("FAIL start_in_fall_next: level=%0d want 9", level);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_basic(16);
        n_tests++;
        if (level !== 4'd15 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_high_pre: level=%0d dir=%0b want 15 1", level, dir);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (level !== 4'd0 || led !== 1'b0 || busy !== 1'b0 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: level=%0d led=%0b busy=%0b dir=%0b want all 0", level,
                     led, busy, dir);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_idle: busy=%0b want 0", busy);
        end
        run_basic(70);
    endtask

    task automatic test_pwm();
        int  highs;
        int  waited;
        int  exp_highs;
        do_reset();
        div   = 16'd1000;
        hold  = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (led === 1'b1) highs++;
        end
        n_tests++;
        if (highs !== 0) begin
            n_fail++;
            $display("FAIL pwm_level0: led high %0d of 16, want 0", highs);
        end
        waited = 0;
        while (level !== 4'd8 && waited < 20000) begin
            step();
            waited++;
        end
        n_tests++;
        if (level !== 4'd8) begin
            n_fail++;
            $display("FAIL pwm_reach8: level=%0d after %0d clks, want 8", level, waited);
        end
        repeat (4) step();
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (led === 1'b1) highs++;
        end
`ifdef BREATH_SEQUENCER_GAMMA_EN
        exp_highs = 4;
`else
        exp_highs = 8;
`endif
        n_tests++;
        if (highs !== exp_highs) begin
            n_fail++;
            $display("FAIL pwm_level8: led high %0d of 16, want %0d", highs, exp_highs);
        end
        do_reset();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_div();
        test_stop();
        test_start_stop_idle();
        test_async_reset();
        test_pwm();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
